// File: rtl/serial_adder_rx.sv
// Bit-serial full-adder receiver: accepts LSB-first operand bit pairs,
// assembles the WIDTH-bit sum and carry-out behind a valid/ready handshake.
module serial_adder_rx #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   input  logic             a_bit,
   input  logic             b_bit,
   output logic             in_ready,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } state_t;

   state_t           state, state_nxt;
   logic             carry, carry_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [WIDTH-1:0] sum_nxt;
   logic             cout_nxt;
   logic             s_bit, c_bit;
   logic [WIDTH-1:0] shifted;

   assign s_bit   = a_bit ^ b_bit ^ carry;
   assign c_bit   = (a_bit & b_bit) | (carry & (a_bit ^ b_bit));
   assign shifted = {s_bit, shreg[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         carry   <= 1'b0;
         cnt     <= '0;
         shreg   <= '0;
         sum_out <= '0;
         cout    <= 1'b0;
      end else begin
         state   <= state_nxt;
         carry   <= carry_nxt;
         cnt     <= cnt_nxt;
         shreg   <= shreg_nxt;
         sum_out <= sum_nxt;
         cout    <= cout_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      carry_nxt = carry;
      cnt_nxt   = cnt;
      shreg_nxt = shreg;
      sum_nxt   = sum_out;
      cout_nxt  = cout;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = ACCUM;
               carry_nxt = 1'b0;
               cnt_nxt   = '0;
               shreg_nxt = '0;
            end
         end
         ACCUM: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) begin
               carry_nxt = c_bit;
               shreg_nxt = shifted;
               cnt_nxt   = cnt + 1'b1;
               // Last bit: publish the word; count restarts for the next one
               if (cnt == LAST) begin
                  cnt_nxt   = '0;
                  sum_nxt   = shifted;
                  cout_nxt  = c_bit;
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_serial_adder_rx.sv
// Directed bench for serial_adder_rx: arithmetic model of the word result
// and handshake phase, checked every cycle on the falling edge.
module tb_serial_adder_rx;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         in_valid = 1'b0;
   logic         a_bit = 1'b0;
   logic         b_bit = 1'b0;
   logic         out_ready = 1'b0;
   logic         in_ready;
   logic [W-1:0] sum_out;
   logic         cout;
   logic         out_valid;
   logic         busy;

   int n_total = 0;
   int n_pass  = 0;

   // Model: phase 0 idle, 1 accumulating, 2 result pending
   int           phase = 0;
   int           nbits = 0;
   bit           chk_en = 1'b0;
   logic [W-1:0] exp_sum = '0;
   logic         exp_cout = 1'b0;
   logic [W-1:0] last_sum = '0;
   logic         last_cout = 1'b0;

   serial_adder_rx #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_valid  (in_valid),
      .a_bit     (a_bit),
      .b_bit     (b_bit),
      .in_ready  (in_ready),
      .sum_out   (sum_out),
      .cout      (cout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("in_ready", 32'(in_ready), 32'(phase == 1));
         check("out_valid", 32'(out_valid), 32'(phase == 2));
         check("busy", 32'(busy), 32'(phase != 0));
         if (phase == 2) begin
            check("sum_out", 32'(sum_out), 32'(exp_sum));
            check("cout", 32'(cout), 32'(exp_cout));
         end else begin
            check("sum_hold", 32'(sum_out), 32'(last_sum));
            check("cout_hold", 32'(cout), 32'(last_cout));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic with_bit);
      start    = 1'b1;
      in_valid = with_bit;
      a_bit    = with_bit;
      b_bit    = with_bit;
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      phase    = 1;
      nbits    = 0;
   endtask

   task automatic send_bit(input logic a, input logic b);
      in_valid = 1'b1;
      a_bit    = a;
      b_bit    = b;
      tick();
      in_valid = 1'b0;
      nbits++;
      if (nbits == W) phase = 2;
   endtask

   task automatic accept();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      phase     = 0;
      last_sum  = exp_sum;
      last_cout = exp_cout;
   endtask

   // gap_at/start_at: bit index before which idle cycles or a stray start go
   task automatic run_word(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int gap_at, input int gap_len,
                           input int start_at, input int stall,
                           input logic [W:0] lit, input string name);
      logic [W:0] full;
      full     = {1'b0, a} + {1'b0, b};
      exp_sum  = full[W-1:0];
      exp_cout = full[W];
      check({name, "_model"}, 32'(full), 32'(lit));
      do_start(1'b0);
      for (int i = 0; i < W; i++) begin
         if (i == gap_at) repeat (gap_len) tick();
         if (i == start_at) begin
            start = 1'b1;
            tick();
            start = 1'b0;
         end
         send_bit(a[i], b[i]);
      end
      check({name, "_lat"}, 32'(out_valid), 32'd1);
      check({name, "_lit"}, 32'({cout, sum_out}), 32'(lit));
      for (int k = 0; k < stall; k++) begin
         start    = k[0];
         in_valid = ~k[0];
         a_bit    = 1'b1;
         b_bit    = 1'b1;
         tick();
      end
      start    = 1'b0;
      in_valid = 1'b0;
      accept();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_sum", 32'(sum_out), 32'd0);
      check("rst_flags", 32'({cout, out_valid, in_ready, busy}), 32'd0);
      rst    = 1'b0;
      chk_en = 1'b1;

      // in_valid in IDLE is ignored
      in_valid = 1'b1;
      a_bit    = 1'b1;
      b_bit    = 1'b1;
      repeat (2) tick();
      in_valid = 1'b0;

      // start with a bit in IDLE: bit must not be consumed
      exp_sum  = 8'h96;
      exp_cout = 1'b0;
      do_start(1'b1);
      for (int i = 0; i < W; i++) begin
         logic [W-1:0] ta, tb;
         ta = 8'h5A;
         tb = 8'h3C;
         send_bit(ta[i], tb[i]);
      end
      check("w1_lit", 32'({cout, sum_out}), 32'h096);
      accept();

      run_word(8'hFF, 8'h01, -1, 0, -1, 0, 9'h100, "ff01");
      run_word(8'h80, 8'h80, -1, 0, -1, 0, 9'h100, "8080");
      run_word(8'h0F, 8'h01, 3, 3, -1, 0, 9'h010, "gap");
      run_word(8'h37, 8'hC4, -1, 0, -1, 5, 9'h0FB, "stall");

      // reset after 4 accepted bits discards the partial word
      exp_sum  = 8'hFF;
      exp_cout = 1'b1;
      do_start(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
      rst      = 1'b1;
      in_valid = 1'b1;
      start    = 1'b1;
      tick();
      rst       = 1'b0;
      in_valid  = 1'b0;
      start     = 1'b0;
      phase     = 0;
      last_sum  = '0;
      last_cout = 1'b0;
      exp_sum   = '0;
      exp_cout  = 1'b0;
      check("rst_mid", 32'({sum_out, cout, out_valid, in_ready, busy}), 32'd0);
      tick();

      run_word(8'h01, 8'h01, -1, 0, -1, 0, 9'h002, "0101");
      run_word(8'hAA, 8'h55, -1, 0, 3, 0, 9'h0FF, "aa55");
      run_word(8'hFF, 8'hFF, 6, 1, 2, 2, 9'h1FE, "ffff");
      repeat (2) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/serial_adder_rx.md
Name: serial_adder_rx

Overview:
- Bit-serial full-adder receiver. Consumes LSB-first operand bit pairs (a_bit, b_bit) under a valid/ready handshake.
- Per bit, computes the half-adder pair (AND for carry generate, XOR for sum) plus a registered carry.
- Deserializes the sum bits into a WIDTH-bit word and presents it with a carry-out under an output valid/ready handshake.
- Sits downstream of the serial operand source. It is the consuming/assembling end of the two-bit adder datapath already in the design.

Parameters:
- WIDTH, 8, operand and result word width in bits (>= 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a new word; honoured only in IDLE.
- in_valid  input  1  a_bit/b_bit are valid this cycle.
- a_bit  input  1  operand A bit, LSB first.
- b_bit  input  1  operand B bit, LSB first.
- in_ready  output  1  high only in ACCUM.
- sum_out  output  WIDTH  assembled sum word; bit 0 = first accepted bit.
- cout  output  1  carry out of the MSB addition.
- out_valid  output  1  sum_out/cout valid; high only in DONE.
- out_ready  input  1  downstream accepts result.
- busy  output  1  high in ACCUM and DONE.

Behaviour:
- Reset (rst=1 at clock edge):
  - state=IDLE, carry=0, bit count=0, shift register=0.
  - sum_out=0, cout=0, out_valid=0, in_ready=0, busy=0.
  - Reset has priority over every other input, including mid-word in ACCUM or DONE. The partial word is discarded.
- States:
  - IDLE: in_ready=0, out_valid=0, busy=0.
    - start=1 -> ACCUM.
    - On entry to ACCUM: carry=0, count=0, shift register cleared.
    - in_valid is ignored.
  - ACCUM: in_ready=1, busy=1.
    - A bit is accepted when in_valid=1 on a clock edge.
    - Sum bit s = a^b^carry.
    - New carry = (a&b) | (carry&(a^b)).
    - s is shifted into the MSB of the shift register, which shifts right, so after WIDTH accepts the first bit sits in bit 0.
    - count increments on each accept. in_valid=0 cycles hold all state; gaps of any length are allowed.
    - On the accept with count==WIDTH-1: sum_out <= final shifted word, cout <= new carry, out_valid <= 1, go to DONE. Total is exactly WIDTH accepts per word.
    - start is ignored.
  - DONE: out_valid=1, in_ready=0, busy=1.
    - sum_out and cout are held stable while out_valid=1 and out_ready=0.
    - out_ready=1 -> IDLE next cycle, out_valid=0 next cycle. sum_out and cout retain their last value.
    - start and in_valid are ignored.
- Latency:
  - Result is valid the cycle after the WIDTH-th accepted bit.
  - Minimum word period is WIDTH+2 cycles (start, WIDTH accepts, 1 DONE cycle with out_ready=1).
- Width rules:
  - sum_out = (A+B) mod 2^WIDTH.
  - cout = bit WIDTH of A+B.
  - Count register is ceil(log2(WIDTH)) bits; it never wraps within a word.
- Simultaneous events:
  - start together with in_valid in IDLE: only start takes effect; the bit is not consumed.
  - rst with any other input: rst wins.

Test Plan:
- start; feed A=8'h5A, B=8'h3C LSB-first, back-to-back -> out_valid 1 cycle after 8th bit, sum_out=8'h96, cout=0.
- start; A=8'hFF, B=8'h01 -> sum_out=8'h00, cout=1. Then A=8'h80, B=8'h80 -> sum_out=8'h00, cout=1. Confirm carry cleared between words.
- A=8'h0F, B=8'h01 with in_valid deasserted for 3 cycles between bits 2 and 3 -> sum_out=8'h10, cout=0; no bits lost or duplicated.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid, sum_out and cout stable; extra start and in_valid pulses ignored; on out_ready=1 returns to IDLE.
- Assert rst after 4 bits accepted -> next cycle all outputs 0, state IDLE. New word 8'h01+8'h01 -> sum_out=8'h02, cout=0.
- start pulse during ACCUM after 3 bits -> ignored; word completes with correct sum for A=8'hAA, B=8'h55 -> sum_out=8'hFF, cout=0.
